// File: rtl/multi_abstract_counter.sv
// Bank of independent up/down occupancy counters with per-channel EMPTY/INTERMEDIATE/FULL
// tracking, occupancy flags and sticky overflow/underflow errors.
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_EMPTY     | count == 0
// ST_INTER     | 0 < count < DEPTH
// ST_FULL      | count == DEPTH
// (2'b11)      | illegal; recovers to ST_EMPTY with count 0
module multi_abstract_counter #(
  parameter int unsigned CHANNELS           = 4,
  parameter int unsigned DEPTH              = 16,
  parameter bit          SATURATE           = 1'b0,
  parameter int unsigned ALMOST_FULL_LEVEL  = DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 2,
  localparam int unsigned CW                = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [CHANNELS-1:0]    increment,
  input  logic [CHANNELS-1:0]    decrement,
  input  logic [CHANNELS-1:0]    clear,
  output logic [CHANNELS*CW-1:0] count,
  output logic [CHANNELS-1:0]    full,
  output logic [CHANNELS-1:0]    empty,
  output logic [CHANNELS-1:0]    almost_full,
  output logic [CHANNELS-1:0]    almost_empty,
  output logic [CHANNELS-1:0]    overflow,
  output logic [CHANNELS-1:0]    underflow,
  output logic                   error_any
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_INTER = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t              st_q  [CHANNELS];
  logic   [CW-1:0]     cnt_q [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] unf_q;
  logic [CHANNELS-1:0] inc_only;
  logic [CHANNELS-1:0] dec_only;

  // Simultaneous increment and decrement cancel out, so only the net request matters.
  assign inc_only = increment & ~decrement;
  assign dec_only = decrement & ~increment;

  always_ff @(posedge clock) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!reset_n || clear[i]) begin
        st_q[i]  <= ST_EMPTY;
        cnt_q[i] <= '0;
        ovf_q[i] <= 1'b0;
        unf_q[i] <= 1'b0;
      end else begin
        case (st_q[i])
          ST_EMPTY: begin
            if (inc_only[i]) begin
              cnt_q[i] <= ONE;
              st_q[i]  <= (DEPTH == 1) ? ST_FULL : ST_INTER;
            end else if (dec_only[i]) begin
              unf_q[i] <= 1'b1;
              if (!SATURATE) begin
                cnt_q[i] <= DEPTH_C;
                st_q[i]  <= ST_FULL;
              end
            end
          end
          ST_INTER: begin
            if (inc_only[i]) begin
              cnt_q[i] <= cnt_q[i] + ONE;
              if (cnt_q[i] == DEPTH_M1) st_q[i] <= ST_FULL;
            end else if (dec_only[i]) begin
              cnt_q[i] <= cnt_q[i] - ONE;
              if (cnt_q[i] == ONE) st_q[i] <= ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (inc_only[i]) begin
              ovf_q[i] <= 1'b1;
              if (!SATURATE) begin
                cnt_q[i] <= '0;
                st_q[i]  <= ST_EMPTY;
              end
            end else if (dec_only[i]) begin
              cnt_q[i] <= DEPTH_M1;
              st_q[i]  <= ST_INTER;
            end
          end
          default: begin
            st_q[i]  <= ST_EMPTY;
            cnt_q[i] <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    count        = '0;
    full         = '0;
    empty        = '0;
    almost_full  = '0;
    almost_empty = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count[i*CW +: CW] = cnt_q[i];
      empty[i]          = (st_q[i] == ST_EMPTY);
      full[i]           = (st_q[i] == ST_FULL);
      almost_full[i]    = (32'(cnt_q[i]) >= ALMOST_FULL_LEVEL);
      almost_empty[i]   = (32'(cnt_q[i]) <= ALMOST_EMPTY_LEVEL);
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign error_any = |{ovf_q, unf_q};

endmodule

// File: tb/tb_multi_abstract_counter.sv
// Drives a wrapping and a saturating counter bank with directed and random requests and
// checks every cycle against an occupancy model of each channel.
module tb_multi_abstract_counter;

  localparam int NCH = 4;
  localparam int DEPTH = 16;
  localparam int CW = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [NCH-1:0] increment = '0, decrement = '0, clear = '0;

  logic [NCH*CW-1:0] cnt_o [2];
  logic [NCH-1:0] full_o [2], empty_o [2], af_o [2], ae_o [2], ov_o [2], un_o [2];
  logic err_o [2];

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  int m_cnt [2][NCH];
  bit m_ov [2][NCH];
  bit m_un [2][NCH];

  always #5 clock = ~clock;

  multi_abstract_counter #(.CHANNELS(NCH), .DEPTH(DEPTH), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .increment(increment), .decrement(decrement),
    .clear(clear), .count(cnt_o[0]), .full(full_o[0]), .empty(empty_o[0]),
    .almost_full(af_o[0]), .almost_empty(ae_o[0]), .overflow(ov_o[0]),
    .underflow(un_o[0]), .error_any(err_o[0]));

  multi_abstract_counter #(.CHANNELS(NCH), .DEPTH(DEPTH), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset_n(reset_n), .increment(increment), .decrement(decrement),
    .clear(clear), .count(cnt_o[1]), .full(full_o[1]), .empty(empty_o[1]),
    .almost_full(af_o[1]), .almost_empty(ae_o[1]), .overflow(ov_o[1]),
    .underflow(un_o[1]), .error_any(err_o[1]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_cnt(input int d, input int ch);
    logic [NCH*CW-1:0] v;
    v = cnt_o[d];
    return int'(v[ch*CW +: CW]);
  endfunction

  // Occupancy model: net request +1/-1, wrap or hold at the limits, errors are sticky.
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NCH; i++) begin
        int net;
        net = int'(increment[i]) - int'(decrement[i]);
        if (!reset_n || clear[i]) begin
          m_cnt[d][i] = 0; m_ov[d][i] = 0; m_un[d][i] = 0;
        end else if (net == 1) begin
          if (m_cnt[d][i] == DEPTH) begin
            m_ov[d][i] = 1;
            m_cnt[d][i] = (d == 1) ? DEPTH : 0;
          end else m_cnt[d][i] = m_cnt[d][i] + 1;
        end else if (net == -1) begin
          if (m_cnt[d][i] == 0) begin
            m_un[d][i] = 1;
            m_cnt[d][i] = (d == 1) ? 0 : DEPTH;
          end else m_cnt[d][i] = m_cnt[d][i] - 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        logic [NCH-1:0] ef, ee, eaf, eae, eov, eun;
        bit eerr;
        eerr = 0;
        for (int i = 0; i < NCH; i++) begin
          ef[i] = (m_cnt[d][i] == DEPTH);
          ee[i] = (m_cnt[d][i] == 0);
          eaf[i] = (m_cnt[d][i] >= DEPTH - 2);
          eae[i] = (m_cnt[d][i] <= 2);
          eov[i] = m_ov[d][i];
          eun[i] = m_un[d][i];
          eerr = eerr | m_ov[d][i] | m_un[d][i];
          chk($sformatf("model count d%0d ch%0d", d, i), dut_cnt(d, i), m_cnt[d][i]);
        end
        chk($sformatf("model full d%0d", d), int'(full_o[d]), int'(ef));
        chk($sformatf("model empty d%0d", d), int'(empty_o[d]), int'(ee));
        chk($sformatf("model almost_full d%0d", d), int'(af_o[d]), int'(eaf));
        chk($sformatf("model almost_empty d%0d", d), int'(ae_o[d]), int'(eae));
        chk($sformatf("model overflow d%0d", d), int'(ov_o[d]), int'(eov));
        chk($sformatf("model underflow d%0d", d), int'(un_o[d]), int'(eun));
        chk($sformatf("model error_any d%0d", d), int'(err_o[d]), int'(eerr));
      end
    end
  end

  // Apply one cycle of requests; returns at the following negedge with outputs settled.
  task automatic step(input logic [NCH-1:0] inc, input logic [NCH-1:0] dec,
                      input logic [NCH-1:0] clr, input logic rn);
    increment = inc; decrement = dec; clear = clr; reset_n = rn;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    step('0, '0, '0, 1'b0);
    checking = 1;
    chk("reset empty", int'(empty_o[0]), 15);
    chk("reset almost_empty", int'(ae_o[0]), 15);
    chk("reset full", int'(full_o[0]), 0);
    chk("reset almost_full", int'(af_o[0]), 0);
    chk("reset error_any", int'(err_o[0]), 0);

    for (int k = 1; k <= 16; k++) begin
      step(4'b0001, '0, '0, 1'b1);
      if (k == 13) chk("af0 low at 13", int'(af_o[0][0]), 0);
      if (k == 14) chk("af0 high at 14", int'(af_o[0][0]), 1);
    end
    chk("ch0 count 16", dut_cnt(0, 0), 16);
    chk("ch0 full", int'(full_o[0][0]), 1);
    chk("other ch empty", int'(empty_o[0][3:1]), 7);

    for (int k = 0; k < 16; k++) step(4'b0010, '0, '0, 1'b1);
    step(4'b0010, '0, '0, 1'b1);
    chk("wrap ch1 count", dut_cnt(0, 1), 0);
    chk("wrap ch1 empty", int'(empty_o[0][1]), 1);
    chk("wrap ch1 overflow", int'(ov_o[0][1]), 1);
    chk("wrap error_any", int'(err_o[0]), 1);
    chk("sat ch1 count", dut_cnt(1, 1), 16);
    step('0, '0, 4'b0010, 1'b1);
    chk("clear ch1 overflow", int'(ov_o[0][1]), 0);

    step('0, 4'b0100, '0, 1'b1);
    chk("sat ch2 underflow count", dut_cnt(1, 2), 0);
    chk("sat ch2 underflow", int'(un_o[1][2]), 1);
    chk("wrap ch2 underflow count", dut_cnt(0, 2), 16);
    step('0, '0, 4'b0100, 1'b1);
    for (int k = 0; k < 16; k++) step(4'b0100, '0, '0, 1'b1);
    step(4'b0100, '0, '0, 1'b1);
    chk("sat ch2 hold 16", dut_cnt(1, 2), 16);
    chk("sat ch2 overflow", int'(ov_o[1][2]), 1);

    step(4'b1000, 4'b1000, '0, 1'b1);
    chk("both at 0", dut_cnt(0, 3), 0);
    for (int k = 0; k < 5; k++) step(4'b1000, '0, '0, 1'b1);
    step(4'b1000, 4'b1000, '0, 1'b1);
    chk("both at 5", dut_cnt(0, 3), 5);
    for (int k = 0; k < 11; k++) step(4'b1000, '0, '0, 1'b1);
    step(4'b1000, 4'b1000, '0, 1'b1);
    chk("both at 16", dut_cnt(0, 3), 16);
    chk("both no error ch3", int'(ov_o[0][3] | un_o[0][3]), 0);

    step('0, '0, 4'b0001, 1'b1);
    for (int k = 0; k < 9; k++) step(4'b0001, '0, '0, 1'b1);
    step(4'b0001, '0, 4'b0001, 1'b1);
    chk("clear beats inc count", dut_cnt(0, 0), 0);
    chk("clear beats inc empty", int'(empty_o[0][0]), 1);

    for (int k = 0; k < 3000; k++) begin
      logic [NCH-1:0] inc, dec, clr;
      bit up;
      up = ((k / 200) % 2) == 0;
      for (int i = 0; i < NCH; i++) begin
        inc[i] = up ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
        dec[i] = up ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
        clr[i] = ($urandom_range(0, 63) == 0);
      end
      step(inc, dec, clr, ($urandom_range(0, 499) != 0));
    end

    for (int k = 0; k < 20; k++) step(4'b0111, 4'b1000, '0, 1'b1);
    step(4'b1111, '0, 4'b1111, 1'b0);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NCH; i++) chk($sformatf("reset count d%0d ch%0d", d, i), dut_cnt(d, i), 0);
      chk($sformatf("reset empty d%0d", d), int'(empty_o[d]), 15);
      chk($sformatf("reset flags d%0d", d), int'({full_o[d], af_o[d], ov_o[d], un_o[d]}), 0);
      chk($sformatf("reset err d%0d", d), int'(err_o[d]), 0);
    end

    checking = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
